// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file writeback arbiter: one entry buffer each for execute and load, oldest-first grant.
// Optional pending-write scoreboard output enabled with macro RF_WB_PEND_EN.
module rf_wb_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid_i,
   input  logic [4:0]  ex_dst_i,
   input  logic [31:0] ex_data_i,
   output logic        ex_ready_o,
   input  logic        mem_valid_i,
   input  logic [4:0]  mem_dst_i,
   input  logic [31:0] mem_data_i,
   output logic        mem_ready_o,
   input  logic        stall_i,
   output logic        rf_we_o,
   output logic [4:0]  rf_dst_o,
   output logic [31:0] rf_dst_d_o,
   output logic [31:0] pend_o
);

   typedef enum logic [1:0] {ORD_NONE, ORD_EX_OLD, ORD_MEM_OLD} ord_t;

   typedef struct packed {
      logic        vld;
      logic [4:0]  dst;
      logic [31:0] data;
   } wb_ent_t;

   wb_ent_t exb, memb, exb_nxt, memb_nxt;
   ord_t    ord, ord_nxt;
   logic    gnt_ex, gnt_mem, ex_ret, mem_ret, ex_acc, mem_acc, ex_fill, mem_fill;

   // With both buffers valid ord is never NONE, so exactly one grant is live.
   always_comb begin
      gnt_ex      = exb.vld  & (~memb.vld | (ord == ORD_EX_OLD));
      gnt_mem     = memb.vld & (~exb.vld  | (ord == ORD_MEM_OLD));
      ex_ret      = gnt_ex  & ~stall_i;
      mem_ret     = gnt_mem & ~stall_i;
      ex_ready_o  = ~exb.vld  | ex_ret;
      mem_ready_o = ~memb.vld | mem_ret;
      ex_acc      = ex_valid_i  & ex_ready_o;
      mem_acc     = mem_valid_i & mem_ready_o;
      ex_fill     = ex_acc  & (|ex_dst_i);
      mem_fill    = mem_acc & (|mem_dst_i);
   end

   // Writes to x0 are accepted to keep the handshake moving, then dropped.
   always_comb begin
      exb_nxt  = exb;
      memb_nxt = memb;
      if (ex_ret)  exb_nxt.vld  = 1'b0;
      if (mem_ret) memb_nxt.vld = 1'b0;
      if (ex_acc) begin
         exb_nxt.vld  = ex_fill;
         exb_nxt.dst  = ex_dst_i;
         exb_nxt.data = ex_data_i;
      end
      if (mem_acc) begin
         memb_nxt.vld  = mem_fill;
         memb_nxt.dst  = mem_dst_i;
         memb_nxt.data = mem_data_i;
      end
   end

   // A buffer filled this edge is always the younger one; same-edge fills treat the load as older.
   always_comb begin
      ord_nxt = ord;
      if (!(exb_nxt.vld && memb_nxt.vld)) ord_nxt = ORD_NONE;
      else if (ex_fill && mem_fill)       ord_nxt = ORD_MEM_OLD;
      else if (mem_fill)                  ord_nxt = ORD_EX_OLD;
      else if (ex_fill)                   ord_nxt = ORD_MEM_OLD;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ord <= ORD_NONE;
      end else begin
         ord <= ord_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exb  <= '0;
         memb <= '0;
      end else begin
         exb  <= exb_nxt;
         memb <= memb_nxt;
      end
   end

   always_comb begin
      rf_we_o    = ex_ret | mem_ret;
      rf_dst_o   = 5'd0;
      rf_dst_d_o = 32'h0;
      if (gnt_ex) begin
         rf_dst_o   = exb.dst;
         rf_dst_d_o = exb.data;
      end else if (gnt_mem) begin
         rf_dst_o   = memb.dst;
         rf_dst_d_o = memb.data;
      end
   end

`ifdef RF_WB_PEND_EN
   // Valid buffers never hold dst 0, so bit 0 stays clear.
   always_comb begin
      pend_o = 32'h0;
      if (exb.vld)  pend_o[exb.dst]  = 1'b1;
      if (memb.vld) pend_o[memb.dst] = 1'b1;
   end
`else
   assign pend_o = 32'h0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: ordering, stall hold, x0 discard, async reset, pend scoreboard.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid_i, mem_valid_i, stall_i;
   logic [4:0]  ex_dst_i, mem_dst_i;
   logic [31:0] ex_data_i, mem_data_i;
   logic        ex_ready_o, mem_ready_o, rf_we_o;
   logic [4:0]  rf_dst_o;
   logic [31:0] rf_dst_d_o, pend_o;

   int nerr = 0;
   int nchk = 0;
   int wr7  = 0;
   logic [31:0] rf [32];

   rf_wb_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid_i(ex_valid_i), .ex_dst_i(ex_dst_i), .ex_data_i(ex_data_i), .ex_ready_o(ex_ready_o),
      .mem_valid_i(mem_valid_i), .mem_dst_i(mem_dst_i), .mem_data_i(mem_data_i), .mem_ready_o(mem_ready_o),
      .stall_i(stall_i), .rf_we_o(rf_we_o), .rf_dst_o(rf_dst_o), .rf_dst_d_o(rf_dst_d_o), .pend_o(pend_o)
   );

   always #5 clk = ~clk;

   // Register-file model: commits on the edge where the write is presented.
   always @(posedge clk) begin
      if (rf_we_o) begin
         rf[rf_dst_o] <= rf_dst_d_o;
         if (rf_dst_o == 5'd7) wr7 <= wr7 + 1;
      end
   end

   function automatic logic [31:0] pe(input logic [31:0] m);
`ifdef RF_WB_PEND_EN
      return m;
`else
      return 32'h0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input string tag, input logic we, input logic [4:0] d, input logic [31:0] v);
      chk({tag, "_we"}, {31'h0, rf_we_o}, {31'h0, we});
      chk({tag, "_dst"}, {27'h0, rf_dst_o}, {27'h0, d});
      chk({tag, "_data"}, rf_dst_d_o, v);
   endtask

   task automatic rdy(input string tag, input logic e, input logic m);
      chk({tag, "_exrdy"}, {31'h0, ex_ready_o}, {31'h0, e});
      chk({tag, "_memrdy"}, {31'h0, mem_ready_o}, {31'h0, m});
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      rst_n = 1'b0; stall_i = 1'b0;
      ex_valid_i = 1'b0; ex_dst_i = 5'd0; ex_data_i = 32'h0;
      mem_valid_i = 1'b0; mem_dst_i = 5'd0; mem_data_i = 32'h0;
      #2;
      wr("rst", 1'b0, 5'd0, 32'h0);
      chk("rst_pend", pend_o, 32'h0);
      rdy("rst", 1'b1, 1'b1);
      step(); step();
      rst_n = 1'b1;
      step();

      // single ex write, one-cycle latency
      ex_valid_i = 1'b1; ex_dst_i = 5'd5; ex_data_i = 32'hA5A5_0001;
      step();
      ex_valid_i = 1'b0;
      wr("ex1", 1'b1, 5'd5, 32'hA5A5_0001);
      chk("ex1_pend", pend_o, pe(32'h0000_0020));
      step();
      wr("ex1_after", 1'b0, 5'd0, 32'h0);
      chk("x5", rf[5], 32'hA5A5_0001);

      // same-edge capture: load older
      ex_valid_i = 1'b1; ex_dst_i = 5'd3; ex_data_i = 32'h1111_0003;
      mem_valid_i = 1'b1; mem_dst_i = 5'd3; mem_data_i = 32'h2222_0003;
      step();
      ex_valid_i = 1'b0; mem_valid_i = 1'b0;
      wr("same1", 1'b1, 5'd3, 32'h2222_0003);
      rdy("same1", 1'b0, 1'b1);
      step();
      wr("same2", 1'b1, 5'd3, 32'h1111_0003);
      step();
      wr("same3", 1'b0, 5'd0, 32'h0);
      chk("x3", rf[3], 32'h1111_0003);

      // x0 write discarded
      mem_valid_i = 1'b1; mem_dst_i = 5'd0; mem_data_i = 32'hDEAD_BEEF;
      step();
      mem_valid_i = 1'b0;
      wr("x0", 1'b0, 5'd0, 32'h0);
      chk("x0_pend", pend_o, 32'h0);
      rdy("x0", 1'b1, 1'b1);
      step();
      chk("x0_we2", {31'h0, rf_we_o}, 32'h0);

      // both full under 3-cycle stall, then back-to-back drain
      stall_i = 1'b1;
      ex_valid_i = 1'b1; ex_dst_i = 5'd10; ex_data_i = 32'hAAAA_000A;
      mem_valid_i = 1'b1; mem_dst_i = 5'd11; mem_data_i = 32'hBBBB_000B;
      step();
      ex_valid_i = 1'b0; mem_valid_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         wr("stall", 1'b0, 5'd11, 32'hBBBB_000B);
         rdy("stall", 1'b0, 1'b0);
         chk("stall_pend", pend_o, pe(32'h0000_0C00));
         if (c < 2) step();
      end
      stall_i = 1'b0;
      #1;
      wr("drain1", 1'b1, 5'd11, 32'hBBBB_000B);
      step();
      wr("drain2", 1'b1, 5'd10, 32'hAAAA_000A);
      step();
      wr("drain3", 1'b0, 5'd0, 32'h0);

      // mem fills behind a stalled ex entry: ex is older
      stall_i = 1'b1;
      ex_valid_i = 1'b1; ex_dst_i = 5'd4; ex_data_i = 32'h4444_0004;
      step();
      ex_valid_i = 1'b0;
      mem_valid_i = 1'b1; mem_dst_i = 5'd6; mem_data_i = 32'h6666_0006;
      step();
      mem_valid_i = 1'b0;
      rdy("exold", 1'b0, 1'b0);
      stall_i = 1'b0;
      #1;
      wr("exold1", 1'b1, 5'd4, 32'h4444_0004);
      step();
      wr("exold2", 1'b1, 5'd6, 32'h6666_0006);
      step();
      wr("exold3", 1'b0, 5'd0, 32'h0);

      // pend held through stall, cleared on retiring edge
      stall_i = 1'b1;
      ex_valid_i = 1'b1; ex_dst_i = 5'd9; ex_data_i = 32'h9999_0009;
      step();
      ex_valid_i = 1'b0;
      chk("p9_a", pend_o, pe(32'h0000_0200));
      chk("p9_we", {31'h0, rf_we_o}, 32'h0);
      step();
      chk("p9_b", pend_o, pe(32'h0000_0200));
      stall_i = 1'b0;
      #1;
      chk("p9_c", pend_o, pe(32'h0000_0200));
      wr("p9_wr", 1'b1, 5'd9, 32'h9999_0009);
      step();
      chk("p9_d", pend_o, 32'h0);

      // async reset mid-cycle drops the buffered x7 write
      ex_valid_i = 1'b1; ex_dst_i = 5'd7; ex_data_i = 32'h7777_0007;
      step();
      ex_valid_i = 1'b0;
      wr("x7_pre", 1'b1, 5'd7, 32'h7777_0007);
      chk("x7_pend", pend_o, pe(32'h0000_0080));
      #2 rst_n = 1'b0;
      #1;
      wr("arst", 1'b0, 5'd0, 32'h0);
      chk("arst_pend", pend_o, 32'h0);
      rdy("arst", 1'b1, 1'b1);
      step();
      rst_n = 1'b1;
      step(); step();
      chk("x7_writes", wr7, 0);
      wr("post_rst", 1'b0, 5'd0, 32'h0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on posedge clk.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have ports ex_valid_i (input, 1), ex_dst_i (input, 5), ex_data_i (input, 32), ex_ready_o (output, 1): execute-stage writeback request, valid/ready handshake.
REQ-004 SHALL have ports mem_valid_i (input, 1), mem_dst_i (input, 5), mem_data_i (input, 32), mem_ready_o (output, 1): load-unit writeback request, valid/ready handshake.
REQ-005 SHALL have port stall_i, input, 1: register-file write port blocked this cycle.
REQ-006 SHALL have ports rf_we_o (output, 1), rf_dst_o (output, 5), rf_dst_d_o (output, 32): single register-file write port.
REQ-007 SHALL have port pend_o, output, 32: bit k set = buffered, uncommitted write to xk.

Function
REQ-008 SHALL hold one entry buffer per requester (EXB, MEMB: valid, dst, data).
REQ-009 SHALL accept a request on a posedge where valid_i && ready_o; capture dst/data into that requester's buffer.
REQ-010 SHALL drive ready_o = ~buf_valid | (buffer granted && ~stall_i), the same cycle.
REQ-011 SHALL accept a request with dst == 0 and then discard it; it is never granted and never sets pend_o.
REQ-012 SHALL track age in order state ORD ∈ {NONE, EX_OLD, MEM_OLD}; NONE = fewer than two buffers valid.
REQ-013 SHALL grant the only valid buffer when one is valid. When both are valid, it SHALL grant EXB in EX_OLD and MEMB in MEM_OLD.
REQ-014 SHALL transition ORD to EX_OLD when MEMB fills while EXB is valid and is not retiring. The converse case SHALL go to MEM_OLD.
REQ-015 SHALL transition ORD to MEM_OLD when both buffers are captured on the same edge (load is the older instruction).
REQ-016 SHALL transition ORD to NONE whenever at most one buffer is valid after the edge. If the granted buffer retires and is refilled on the same edge, the other buffer becomes older.
REQ-017 SHALL drive rf_we_o = granted buffer valid && ~stall_i. rf_dst_o/rf_dst_d_o SHALL come from the granted buffer, and SHALL be 0 when nothing is granted.
REQ-018 SHALL retire the granted entry on a posedge where rf_we_o = 1.
REQ-019 SHALL have latency: accept at edge E -> rf_we_o high in cycle after E, if it is granted and stall_i = 0; no combinational path from valid_i to rf_we_o.
REQ-020 SHALL never assert rf_we_o twice for one accepted entry. Throughput SHALL be 1 write per cycle sustained.
REQ-021 SHALL hold buffered contents and ORD unchanged while stall_i = 1.
REQ-022 SHALL set pend_o[d] when any valid buffer holds dst d ≠ 0, and clear it the edge the last such entry retires.

Reset
REQ-023 SHALL, while rst_n = 0 (asynchronously): clear both buffer valids and set ORD = NONE. It SHALL then drive rf_we_o = 0, rf_dst_o = 0, rf_dst_d_o = 0, pend_o = 0, ex_ready_o = 1, mem_ready_o = 1.
REQ-024 SHALL drop buffered entries on reset mid-operation, with no write issued.

Configuration
REQ-025 SHALL, with macro RF_WB_PEND_EN defined, implement pend_o per REQ-007/REQ-022.
REQ-026 SHALL, without RF_WB_PEND_EN, tie pend_o to 32'h0 and synthesise no pend logic.

Verification
REQ-027 SHALL cover: ex accept dst=5 data=32'hA5A5_0001, stall_i=0 -> next cycle rf_we_o=1, rf_dst_o=5, rf_dst_d_o=32'hA5A5_0001; the cycle after, rf_we_o=0.
REQ-028 SHALL cover: ex dst=3 and mem dst=3 accepted on the same edge -> mem data written first, ex data written next cycle; x3 final value = ex data.
REQ-029 SHALL cover: mem dst=0 accepted -> rf_we_o stays 0; pend_o=0; mem_ready_o=1 next cycle.
REQ-030 SHALL cover: both buffers full, stall_i=1 for 3 cycles -> rf_we_o=0, ex_ready_o=mem_ready_o=0, buffers unchanged; on release, two writes in consecutive cycles.
REQ-031 SHALL cover: ex dst=7 buffered, rst_n pulsed low mid-cycle -> immediately rf_we_o=0, pend_o=0, both ready_o=1; no write to x7 afterwards.
REQ-032 SHALL cover: RF_WB_PEND_EN defined, ex dst=9 accepted with stall_i=1 -> pend_o=32'h0000_0200 until the retiring edge, then 0; with the macro undefined, pend_o stays 0.
